// File: rtl/video_pattern_gen_if.sv
// Configuration inputs and video outputs of the test-pattern generator.
interface video_pattern_gen_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   en;
  logic [1:0]             pattern;
  logic [15:0]            width;
  logic [15:0]            height;
  logic [15:0]            hblank;
  logic [15:0]            vblank;
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;
  logic [15:0]            frame_cnt_o;

  modport slave (
    input  en, pattern, width, height, hblank, vblank,
    output do_o, de_o, hs_o, vs_o, frame_cnt_o
  );

  modport master (
    output en, pattern, width, height, hblank, vblank,
    input  do_o, de_o, hs_o, vs_o, frame_cnt_o
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Video test-pattern generator: raster of width x height pixels with line and
// frame blanking, optional sparse data-enable, four selectable patterns.
module video_pattern_gen #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int DE_SPARSE     = 0,
  parameter int LINE_SIZE_MAX = 4096
) (
  input logic                clk,
  input logic                rst,
  video_pattern_gen_if.slave bus
);
  localparam int CW = $clog2(LINE_SIZE_MAX) + 1;
  localparam int SW = (DE_SPARSE > 0) ? $clog2(DE_SPARSE + 1) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(DE_SPARSE);
  localparam logic [15:0]   W_MAX    = 16'(LINE_SIZE_MAX);

  typedef enum logic [1:0] {IDLE, PIX, HBL, VBL} state_t;
  typedef struct packed {
    logic [1:0]  pat;
    logic [15:0] w, h, hb, vb;
  } cfg_t;

  state_t                 state, state_n;
  cfg_t                   cfg, cfg_n;
  logic [CW-1:0]          x, x_n, y, y_n;
  logic [SW-1:0]          sub, sub_n;
  logic [15:0]            cnt, cnt_n, fc, fc_n;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_n;
  logic                   de_q, de_n, hs_q, hs_n, vs_q, vs_n;
  logic                   start, start_ok, eof, last_line;
  logic [15:0]            w_clamp;

  function automatic logic [PIXEL_WIDTH-1:0] pix_val(
    input logic [1:0] pat, input logic [15:0] px, py, f);
    logic [15:0] s;
    s = px + py + f;
    case (pat)
      2'd0:    pix_val = PIXEL_WIDTH'(px);
      2'd1:    pix_val = PIXEL_WIDTH'(py);
      2'd2:    pix_val = {PIXEL_WIDTH{px[3] ^ py[3]}};
      default: pix_val = PIXEL_WIDTH'(s);
    endcase
  endfunction

  assign start_ok = bus.en && (bus.width != 16'd0) && (bus.height != 16'd0);
  assign w_clamp  = (32'(bus.width) > LINE_SIZE_MAX) ? W_MAX : bus.width;

  always_comb begin
    state_n   = state;
    cfg_n     = cfg;
    x_n       = x;
    y_n       = y;
    sub_n     = sub;
    cnt_n     = cnt;
    fc_n      = fc;
    eof       = 1'b0;
    start     = 1'b0;
    last_line = (16'(y) == cfg.h - 16'd1);
    case (state)
      IDLE: start = start_ok;
      PIX:
        if (sub == SUB_LAST) begin
          sub_n = '0;
          if (16'(x) == cfg.w - 16'd1) begin
            state_n = HBL;
            cnt_n   = '0;
          end else begin
            x_n = x + CW'(1);
          end
        end else begin
          sub_n = sub + SW'(1);
        end
      // hblank of 0 still costs one cycle: the compare is true on the first one
      HBL:
        if ({1'b0, cnt} + 17'd1 >= {1'b0, cfg.hb}) begin
          if (!last_line) begin
            state_n = PIX;
            x_n     = '0;
            y_n     = y + CW'(1);
          end else if (cfg.vb != 16'd0) begin
            state_n = VBL;
            cnt_n   = '0;
          end else begin
            eof = 1'b1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      VBL:
        if ({1'b0, cnt} + 17'd1 >= {1'b0, cfg.vb}) eof = 1'b1;
        else cnt_n = cnt + 16'd1;
      default: state_n = IDLE;
    endcase

    if (eof) begin
      fc_n  = fc + 16'd1;
      start = start_ok;
      if (!start_ok) state_n = IDLE;
    end
    if (start) begin
      cfg_n   = '{pat: bus.pattern, w: w_clamp, h: bus.height,
                  hb: bus.hblank, vb: bus.vblank};
      x_n     = '0;
      y_n     = '0;
      sub_n   = '0;
      state_n = PIX;
    end

    // Outputs are derived from the next-cycle state so they can be registered
    de_n  = (state_n == PIX) && (sub_n == SUB_LAST);
    pix_n = de_n ? pix_val(cfg_n.pat, 16'(x_n), 16'(y_n), fc_n) : pix_q;
    hs_n  = (state_n != PIX);
    vs_n  = (state_n == PIX) ||
            ((state_n == HBL) && (16'(y_n) != cfg_n.h - 16'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cfg   <= '0;
      x     <= '0;
      y     <= '0;
      sub   <= '0;
      cnt   <= '0;
      fc    <= '0;
      pix_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b0;
    end else begin
      state <= state_n;
      cfg   <= cfg_n;
      x     <= x_n;
      y     <= y_n;
      sub   <= sub_n;
      cnt   <= cnt_n;
      fc    <= fc_n;
      pix_q <= pix_n;
      de_q  <= de_n;
      hs_q  <= hs_n;
      vs_q  <= vs_n;
    end
  end

  assign bus.do_o        = pix_q;
  assign bus.de_o        = de_q;
  assign bus.hs_o        = hs_q;
  assign bus.vs_o        = vs_q;
  assign bus.frame_cnt_o = fc;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench: two generators (DE_SPARSE 0 and 1) share stimulus; a raster
// model queues the expected per-cycle outputs and one monitor checks them.
module tb_video_pattern_gen;
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [7:0]  d;
    logic [15:0] fc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       en_v;
  logic [1:0]       pattern;
  logic [15:0]      width, height, hblank, vblank;
  logic [1:0]       de_s, hs_s, vs_s;
  logic [1:0][7:0]  do_s;
  logic [1:0][15:0] fc_s;

  exp_t        q[2][$];
  logic [7:0]  m_do[2];
  logic [15:0] m_fc[2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    video_pattern_gen_if #(.PIXEL_WIDTH(8)) vif ();
    assign vif.en      = en_v[g];
    assign vif.pattern = pattern;
    assign vif.width   = width;
    assign vif.height  = height;
    assign vif.hblank  = hblank;
    assign vif.vblank  = vblank;
    assign de_s[g]     = vif.de_o;
    assign hs_s[g]     = vif.hs_o;
    assign vs_s[g]     = vif.vs_o;
    assign do_s[g]     = vif.do_o;
    assign fc_s[g]     = vif.frame_cnt_o;
    video_pattern_gen #(.PIXEL_WIDTH(8), .DE_SPARSE(g), .LINE_SIZE_MAX(4096)) dut (
      .clk(clk), .rst(rst), .bus(vif.slave));
  end

  function automatic logic [7:0] pix_ref(input int pat, x, y, f);
    case (pat)
      0:       return 8'(x);
      1:       return 8'(y);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return 8'((x + y + f) % 256);
    endcase
  endfunction

  task automatic push(input int g, input logic de, hs, vs);
    exp_t e;
    e.de = de; e.hs = hs; e.vs = vs; e.d = m_do[g]; e.fc = m_fc[g];
    q[g].push_back(e);
  endtask

  // Raster model: nfr frames back to back, then three idle cycles
  task automatic model(input int g, nfr, pat, wid, hgt, hb, vb, output int last_len);
    int w, hbn;
    w   = (wid > 4096) ? 4096 : wid;
    hbn = (hb == 0) ? 1 : hb;
    last_len = 0;
    if (wid == 0 || hgt == 0) begin
      repeat (8) push(g, 1'b0, 1'b1, 1'b0);
      return;
    end
    for (int f = 0; f < nfr; f++) begin
      for (int y = 0; y < hgt; y++) begin
        for (int x = 0; x < w; x++)
          for (int s = 0; s <= g; s++) begin
            if (s == g) m_do[g] = pix_ref(pat, x, y, int'(m_fc[g]));
            push(g, s == g, 1'b0, 1'b1);
          end
        for (int b = 0; b < hbn; b++) push(g, 1'b0, 1'b1, y != hgt - 1);
      end
      for (int b = 0; b < vb; b++) push(g, 1'b0, 1'b1, 1'b0);
      m_fc[g] = m_fc[g] + 16'd1;
    end
    last_len = hgt * (w * (g + 1) + hbn) + vb;
    repeat (3) push(g, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20000 && (q[0].size() != 0 || q[1].size() != 0); c++)
      @(posedge clk);
    if (q[0].size() != 0 || q[1].size() != 0) begin
      $display("FAIL drain timeout: left %0d/%0d, want 0/0", q[0].size(), q[1].size());
      $fatal(1);
    end
  endtask

  // Called just after a posedge; en is held until each DUT is inside its last frame
  task automatic run(input int nfr, pat, wid, hgt, hb, vb);
    int ll[2];
    en_v = 2'b11; pattern = 2'(pat); width = 16'(wid); height = 16'(hgt);
    hblank = 16'(hb); vblank = 16'(vb);
    @(posedge clk);
    for (int g = 0; g < 2; g++) model(g, nfr, pat, wid, hgt, hb, vb, ll[g]);
    for (int c = 0; c < 20000 && en_v != 2'b00; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) if (q[g].size() < ll[g] + 3) en_v[g] = 1'b0;
    end
    if (en_v != 2'b00) begin
      $display("FAIL en drop timeout: en=%b, want 00", en_v);
      $fatal(1);
    end
    // Scramble inputs while a frame may still be running; they must be ignored
    pattern = 2'($urandom); width = 16'($urandom); height = 16'($urandom);
    hblank = 16'($urandom); vblank = 16'($urandom);
    wait_drain();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++)
      if (q[g].size() != 0) begin
        e = q[g].pop_front();
        checks++;
        if ({de_s[g], hs_s[g], vs_s[g], do_s[g], fc_s[g]} !== e) begin
          errors++;
          $display("FAIL out[%0d] t=%0t: got de=%b hs=%b vs=%b do=%0d fc=%0d, want de=%b hs=%b vs=%b do=%0d fc=%0d",
                   g, $time, de_s[g], hs_s[g], vs_s[g], do_s[g], fc_s[g],
                   e.de, e.hs, e.vs, e.d, e.fc);
        end
      end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en_v = 2'b00; pattern = '0; width = '0; height = '0;
    hblank = '0; vblank = '0;
    for (int g = 0; g < 2; g++) begin m_do[g] = '0; m_fc[g] = '0; end
    @(posedge clk);
    for (int g = 0; g < 2; g++) push(g, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(1, 0, 4, 2, 3, 2);    // en honoured right after reset release
    run(1, 1, 5, 3, 0, 0);    // hblank=0 and vblank=0
    run(1, 2, 20, 18, 2, 0);  // checkerboard crosses bit 3 in x and y
    run(2, 3, 3, 2, 1, 1);
    run(1, 0, 0, 5, 2, 2);    // width 0: stays idle
    run(1, 0, 3, 0, 2, 2);    // height 0: stays idle

    // Reset in the middle of line 1, then restart on the first free cycle
    en_v = 2'b11; pattern = 2'd1; width = 16'd6; height = 16'd3;
    hblank = 16'd2; vblank = 16'd1;
    @(posedge clk);
    begin
      int ll[2];
      for (int g = 0; g < 2; g++) model(g, 1, 1, 6, 3, 2, 1, ll[g]);
    end
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; en_v = 2'b00;
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      q[g].delete(); m_do[g] = '0; m_fc[g] = '0;
      push(g, 1'b0, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run(3, 3, 4, 2, 0, 1);    // three frames: first pixels 0,1,2

    repeat (6)
      run($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(1, 24),
          $urandom_range(1, 5), $urandom_range(0, 4), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: bit width of do_o.
REQ-002 SHALL have parameter DE_SPARSE, default 0: number of de_o=0 cycles inserted before each pixel; 0 means back-to-back pixels.
REQ-003 SHALL have parameter LINE_SIZE_MAX, default 4096: maximum active pixels per line; also sets the x/y counter width to clog2(LINE_SIZE_MAX)+1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: run request; checked at each frame boundary.
REQ-007 SHALL have port pattern, input, 2 bits: pattern select.
REQ-008 SHALL have port width, input, 16 bits: active pixels per line.
REQ-009 SHALL have port height, input, 16 bits: active lines per frame.
REQ-010 SHALL have port hblank, input, 16 bits: blanking cycles after each line.
REQ-011 SHALL have port vblank, input, 16 bits: extra blanking cycles after each frame.
REQ-012 SHALL have port do_o, output, PIXEL_WIDTH bits: pixel data.
REQ-013 SHALL have port de_o, output, 1 bit: pixel valid.
REQ-014 SHALL have port hs_o, output, 1 bit: line blanking; 1 = blank, 0 = active line.
REQ-015 SHALL have port vs_o, output, 1 bit: frame active; 1 = inside frame.
REQ-016 SHALL have port frame_cnt_o, output, 16 bits: completed-frame counter.

Function
REQ-017 SHALL implement FSM states IDLE, PIX, HBL and VBL; all outputs SHALL be registered.
REQ-018 IDLE: when en=1, width!=0 and height!=0 are sampled, SHALL capture width (clamped to LINE_SIZE_MAX), height, hblank, vblank and pattern, SHALL set x=y=0, and SHALL enter PIX; the first PIX output cycle is the next cycle.
REQ-019 PIX: each pixel SHALL occupy DE_SPARSE+1 cycles, with hs_o=0 and vs_o=1 in all of them; de_o=0 for the first DE_SPARSE cycles; de_o=1 with valid do_o on the last cycle.
REQ-020 After pixel x=width-1, SHALL enter HBL with hs_o=1 and de_o=0 for max(hblank,1) cycles.
REQ-021 On the last line (y=height-1), vs_o SHALL fall in the same cycle hs_o rises.
REQ-022 HBL end on a non-last line: SHALL increment y and return to PIX.
REQ-023 HBL end on the last line: SHALL enter VBL (hs_o=1, vs_o=0, de_o=0) for vblank cycles, and SHALL go directly to the end-of-frame step when vblank=0.
REQ-024 End of frame: frame_cnt_o SHALL increment, wrapping 0xFFFF->0.
REQ-025 End of frame: if en=1 and width/height are nonzero, SHALL recapture per REQ-018 and start the next frame without an IDLE cycle; otherwise SHALL go to IDLE.
REQ-026 Deasserting en mid-frame SHALL NOT truncate the frame.
REQ-027 Input changes mid-frame SHALL be ignored until the next capture.
REQ-028 do_o by pattern, truncated to PIXEL_WIDTH: 0 = x; 1 = y; 2 = all bits equal to x[3]^y[3]; 3 = x+y+frame_cnt_o.
REQ-029 do_o SHALL hold its last value while de_o=0.
REQ-030 In IDLE, outputs SHALL be de_o=0, hs_o=1, vs_o=0, with do_o held.

Reset
REQ-031 While rst=1, the cycle after it is sampled SHALL show do_o=0, de_o=0, hs_o=1, vs_o=0 and frame_cnt_o=0, with state IDLE and x=y=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no partial-line completion.
REQ-033 After rst falls, en SHALL be honoured on the first sampled cycle.

Verification
REQ-034 DE_SPARSE=0, width=4, height=2, hblank=3, vblank=2, pattern=0 -> line 0: de_o=1 for 4 cycles with do_o 0,1,2,3 and hs_o=0; then 3 cycles hs_o=1; line 1 identical; vs_o falls together with the last hs_o rise; 2 VBL cycles; frame_cnt_o=1.
REQ-035 DE_SPARSE=1, same sizes -> de_o pattern 0,1,0,1,0,1,0,1 per line with hs_o=0 for all 8 cycles; pixel count per frame = 8.
REQ-036 en held high for 3 frames, pattern=3, PIXEL_WIDTH=8 -> first pixel of frame n equals n; no IDLE gap between frames; frame_cnt_o steps 1,2,3.
REQ-037 en dropped during line 0 -> the frame completes normally, then IDLE with hs_o=1 and vs_o=0.
REQ-038 rst pulsed during PIX -> next cycle shows de_o=0, hs_o=1, vs_o=0, frame_cnt_o=0; a restart with en=1 begins at x=0, y=0.
REQ-039 width=0 with en=1 -> stays in IDLE and de_o never asserts.
REQ-040 hblank=0 -> HBL lasts 1 cycle.
REQ-041 A receiving bench monitor SHALL reconstruct a width x height image matching the pattern.
